// File: rtl/clkdiv_arbiter.sv
// ============================================================================
// Module   : clkdiv_arbiter
// Summary  : One programmable clock divider shared by NREQ requesters.
//            Requesters are granted round-robin, or by fixed priority when
//            CLKDIV_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_arbiter #(
  parameter int NREQ         = 4,
  parameter int CW           = 16,
  parameter int DEFAULT_HALF = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CW-1:0]      half_period,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] active_id,
  output logic                    busy,
  output logic                    clk_div,
  output logic                    tick
);

  localparam int            IW             = $clog2(NREQ);
  localparam logic [CW-1:0] C_DEFAULT_HALF = CW'(DEFAULT_HALF);
  localparam logic [CW-1:0] C_ONE          = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, r_h_cur, w_h_nxt;
  logic            r_clk_div, r_tick, r_busy;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]   r_active_id, w_id_nxt;
  logic            w_wrap, w_boundary;
  logic            w_found;
  logic [IW-1:0]   w_winner, w_idx;
  logic [CW-1:0]   w_half_sel, w_half_clamped;

  // A toggle happens at the end of every half period; the falling one closes
  // a full period and is the only point where the ratio may change.
  assign w_wrap     = (r_cnt == r_h_cur - C_ONE);
  assign w_boundary = w_wrap && r_clk_div;

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_active_id;
    w_idx    = '0;
`ifdef CLKDIV_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = IW'(i);
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`else
    // Scan backwards so the last hit is the first in search order.
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IW'((int'(r_active_id) + i) % NREQ);
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`endif
  end

  assign w_half_sel     = half_period[w_winner*CW +: CW];
  assign w_half_clamped = (w_half_sel == '0) ? C_ONE : w_half_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_id_nxt    = r_active_id;
    w_h_nxt     = r_h_cur;
    case (r_state)
      S_IDLE: begin
        if (w_boundary && w_found) begin
          w_grant_nxt = NREQ'(1) << w_winner;
          w_id_nxt    = w_winner;
          w_h_nxt     = w_half_clamped;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[r_active_id]) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_boundary) begin
          if (w_found) begin
            w_grant_nxt = NREQ'(1) << w_winner;
            w_id_nxt    = w_winner;
            w_h_nxt     = w_half_clamped;
            w_state_nxt = S_RUN;
          end else begin
            w_grant_nxt = '0;
            w_h_nxt     = C_DEFAULT_HALF;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_h_nxt     = C_DEFAULT_HALF;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_h_cur     <= C_DEFAULT_HALF;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= |w_grant_nxt;
      r_active_id <= w_id_nxt;
      r_h_cur     <= w_h_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_clk_div <= ~r_clk_div;
      r_tick    <= 1'b1;
    end else begin
      r_cnt     <= r_cnt + C_ONE;
      r_tick    <= 1'b0;
    end
  end

  assign grant     = r_grant;
  assign active_id = r_active_id;
  assign busy      = r_busy;
  assign clk_div   = r_clk_div;
  assign tick      = r_tick;

endmodule

`default_nettype wire

// File: doc/clkdiv_arbiter.md
Name: clkdiv_arbiter

Overview:
- Shared programmable clock-divider controller.
- Several requesters each ask for a divided clock at their own half-period. The block grants the single divider to one requester at a time (round-robin) and runs it at that requester's ratio.
- Ratio changes happen only at full-period boundaries, so the output never glitches.
- Sits between the system clock and low-rate peripherals that need a slow clock or clock-enable.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 16, width of half-period value and internal counter.
- DEFAULT_HALF, 25, half-period in clk cycles used when nothing is granted (must be ≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held high for the whole time the divider is wanted.
- half_period  in  NREQ*CW  requester i's half-period at bits [i*CW +: CW].
- grant  out  NREQ  one-hot grant, all zero when idle.
- active_id  out  $clog2(NREQ)  index of the last or current grant holder.
- busy  out  1  high when grant is nonzero.
- clk_div  out  1  divided clock level.
- tick  out  1  one-cycle pulse on every clk_div toggle.

Behaviour:
- Reset (async) values:
  - cnt=0, clk_div=0, tick=0, grant=0, busy=0, active_id=0.
  - h_cur=DEFAULT_HALF, state=IDLE.
- Divider core:
  - cnt counts 0..h_cur-1, incrementing on every clk edge.
  - On the edge where cnt==h_cur-1: cnt←0, clk_div toggles, tick←1. On all other edges tick←0.
  - Period is 2*h_cur clk cycles, 50% duty.
- Boundary: the edge where cnt==h_cur-1 and clk_div==1, i.e. the falling toggle. All grant, state and h_cur changes occur only on a boundary edge.
- Half-period clamp: a latched half_period of 0 is treated as 1 (clk/2). Width is CW, with no wrap beyond CW bits.
- h_cur is latched from the requester's half_period at grant time. Later changes to that half_period are ignored until the next grant.
- States:
  - IDLE: grant=0, h_cur=DEFAULT_HALF. At a boundary with any req high, arbitrate: grant←onehot(winner), active_id←winner, h_cur←clamp(half_period[winner]), go to RUN. The new h_cur governs counting from the next cycle, starting in the low phase.
  - RUN: when req[active_id] is low, go to DRAIN on the next edge. grant stays asserted.
  - DRAIN: at the next boundary, release the grant. If any req is high, arbitrate again on the same edge (back-to-back grant) and stay in RUN. Otherwise grant←0, h_cur←DEFAULT_HALF, go to IDLE.
  - If req[active_id] reasserts while in DRAIN: the drain still completes, and the requester competes normally in the arbitration on that boundary.
- Arbitration: round-robin. Search starts at (active_id+1) mod NREQ and takes the first req high. active_id keeps the last winner while idle.
- Latency: req to grant is at most 2*h_cur+1 cycles of the currently running ratio.
- busy equals |grant, registered together with grant.
- Reset asserted mid-operation: all state returns to reset values immediately. clk_div may be truncated; that is acceptable only on reset.

Optional Feature:
- Macro CLKDIV_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin. The lowest index with req high wins, regardless of active_id.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both cases.

Test Plan (NREQ=4, CW=8, DEFAULT_HALF=4):
- Reset released, req=0 → clk_div first rises after 4 edges and has period 8. tick pulses every 4 cycles. grant=0, busy=0.
- req[1]=1 with half_period[1]=2 while clk_div is high → grant=0010 exactly at the next falling toggle. Afterwards clk_div period=4, active_id=1, busy=1. Changing half_period[1] to 9 while granted has no effect.
- req[0] and req[2] both high at the boundary, active_id=1 → grant=0100. Drop req[2] → grant=0001 at the following boundary (with CLKDIV_FIXED_PRIO_EN: grant=0001 first).
- half_period[3]=0, sole requester → clk_div toggles every cycle (period 2), tick constantly high.
- Drop req during the high phase of a half=6 grant → grant held until the falling toggle (no truncated high phase). Then grant=0 and the period returns to 8.
- Assert rst for 1 cycle during RUN → clk_div=0, grant=0, cnt=0 immediately. After release, behaviour matches the first scenario.
